// File: rtl/dp_controller.sv
// Issuing-side control FSM for the ARM32 datapath: accepts one data-processing
// instruction, checks its condition, then sequences operand load, execute and done.
module dp_controller #(
    parameter int NZCV_LSB = 28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic [31:0] status_in,
    output logic [3:0]  w_addr,
    output logic        w_en,
    output logic [3:0]  A_addr,
    output logic [3:0]  B_addr,
    output logic [3:0]  shift_addr,
    output logic        en_A,
    output logic        en_B,
    output logic        en_S,
    output logic [1:0]  shift_op,
    output logic [31:0] shift_imme,
    output logic        sel_shift,
    output logic        sel_A,
    output logic        sel_B,
    output logic [31:0] imme_data,
    output logic [2:0]  ALU_op,
    output logic        en_status,
    output logic        wb_sel,
    output logic        done,
    output logic        skipped,
    output logic        illegal
);

    typedef enum logic [2:0] {IDLE, CHECK, LOAD, EXEC, DONE} state_t;

    state_t      state;
    logic [31:0] ir;
    logic [3:0]  nzcv;
    logic        legal;
    logic        writes;
    logic        flags_forced;
    logic        zero_a;
    logic [2:0]  alu_code;
    logic        unused_status;

    assign nzcv          = status_in[NZCV_LSB+3:NZCV_LSB];
    assign unused_status = ^status_in;

    assign A_addr     = ir[19:16];
    assign B_addr     = ir[3:0];
    assign shift_addr = ir[11:8];
    assign w_addr     = ir[15:12];
    assign shift_op   = ir[6:5];
    assign sel_shift  = ir[4];
    assign shift_imme = {27'b0, ir[11:7]};
    assign sel_B      = ir[25];
    assign imme_data  = rotate_imm(ir[7:0], ir[11:8]);
    assign wb_sel     = 1'b0;

    function automatic logic [31:0] rotate_imm(input logic [7:0] imm8, input logic [3:0] rot);
        logic [63:0] doubled;
        doubled = {24'b0, imm8, 24'b0, imm8} >> {rot, 1'b0};
        return doubled[31:0];
    endfunction

    // Flags are N,Z,C,V from msb to lsb of the nzcv slice.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return c;
            4'h3:    return !c;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return c && !z;
            4'h9:    return !c || z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return !z && (n == v);
            4'hD:    return z || (n != v);
            4'hE:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        legal        = 1'b1;
        writes       = 1'b1;
        flags_forced = 1'b0;
        zero_a       = 1'b0;
        alu_code     = 3'b000;
        case (ir[24:21])
            4'b0000: alu_code = 3'b010;
            4'b0001: alu_code = 3'b100;
            4'b0010: alu_code = 3'b001;
            4'b0100: alu_code = 3'b000;
            4'b1000: begin alu_code = 3'b010; writes = 1'b0; flags_forced = 1'b1; end
            4'b1010: begin alu_code = 3'b001; writes = 1'b0; flags_forced = 1'b1; end
            4'b1100: alu_code = 3'b011;
            4'b1101: begin alu_code = 3'b000; zero_a = 1'b1; end
            default: legal = 1'b0;
        endcase
        if (ir[27:26] != 2'b00) legal = 1'b0;
    end

    // Outputs are registered: each is set on the edge entering the state that owns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ir          <= '0;
            instr_ready <= 1'b1;
            en_A        <= 1'b0;
            en_B        <= 1'b0;
            en_S        <= 1'b0;
            w_en        <= 1'b0;
            en_status   <= 1'b0;
            sel_A       <= 1'b0;
            ALU_op      <= 3'b000;
            done        <= 1'b0;
            skipped     <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            en_A      <= 1'b0;
            en_B      <= 1'b0;
            en_S      <= 1'b0;
            w_en      <= 1'b0;
            en_status <= 1'b0;
            sel_A     <= 1'b0;
            ALU_op    <= 3'b000;
            done      <= 1'b0;
            skipped   <= 1'b0;
            illegal   <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ir          <= instr;
                        instr_ready <= 1'b0;
                        state       <= CHECK;
                    end
                end
                CHECK: begin
                    if (!legal) begin
                        done    <= 1'b1;
                        illegal <= 1'b1;
                        state   <= DONE;
                    end else if (!cond_pass(ir[31:28], nzcv)) begin
                        done    <= 1'b1;
                        skipped <= 1'b1;
                        state   <= DONE;
                    end else begin
                        en_A  <= 1'b1;
                        en_B  <= 1'b1;
                        en_S  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    ALU_op    <= alu_code;
                    sel_A     <= zero_a;
                    w_en      <= writes;
                    en_status <= ir[20] | flags_forced;
                    state     <= EXEC;
                end
                EXEC: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: begin
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dp_controller.sv
// Bench for dp_controller: directed instructions plus random ones, compared cycle by
// cycle against an instruction-level model of the expected control schedule.
module tb_dp_controller;

    localparam int NZ = 28;

    logic        clk = 1'b0;
    logic        rst, instr_valid;
    logic [31:0] instr, status_in;
    logic        instr_ready, w_en, en_A, en_B, en_S, sel_shift, sel_A, sel_B;
    logic        en_status, wb_sel, done, skipped, illegal;
    logic [3:0]  w_addr, A_addr, B_addr, shift_addr;
    logic [1:0]  shift_op;
    logic [31:0] shift_imme, imme_data;
    logic [2:0]  ALU_op;

    int tests = 0;
    int fails = 0;

    dp_controller #(.NZCV_LSB(NZ)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .status_in(status_in), .w_addr(w_addr), .w_en(w_en),
        .A_addr(A_addr), .B_addr(B_addr), .shift_addr(shift_addr), .en_A(en_A),
        .en_B(en_B), .en_S(en_S), .shift_op(shift_op), .shift_imme(shift_imme),
        .sel_shift(sel_shift), .sel_A(sel_A), .sel_B(sel_B), .imme_data(imme_data),
        .ALU_op(ALU_op), .en_status(en_status), .wb_sel(wb_sel), .done(done),
        .skipped(skipped), .illegal(illegal)
    );

    always #5 clk = ~clk;

    wire [14:0]  ctrl_obs = {instr_ready, en_A, en_B, en_S, w_en, en_status, sel_A,
                             ALU_op, done, skipped, illegal, wb_sel};
    wire [127:0] fld_obs  = {44'b0, w_addr, A_addr, B_addr, shift_addr, shift_op,
                             sel_shift, sel_B, shift_imme, imme_data};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] mk_ctrl(input bit rdy, input bit ld, input bit wen,
                                            input bit est, input bit sa, input logic [2:0] op,
                                            input bit dn, input bit sk, input bit il);
        return {rdy, ld, ld, ld, wen, est, sa, op, dn, sk, il, 1'b0};
    endfunction

    // Instruction-set view: which opcodes exist, what they compute and whether they write.
    task automatic decode(input logic [31:0] ir, output bit legal, output logic [2:0] op,
                          output bit wr, output bit mv, output bit forced);
        legal = 1; wr = 1; mv = 0; forced = 0; op = 3'b000;
        case (ir[24:21])
            4'd0:  op = 3'b010;
            4'd1:  op = 3'b100;
            4'd2:  op = 3'b001;
            4'd4:  op = 3'b000;
            4'd8:  begin op = 3'b010; wr = 0; forced = 1; end
            4'd10: begin op = 3'b001; wr = 0; forced = 1; end
            4'd12: op = 3'b011;
            4'd13: begin op = 3'b000; mv = 1; end
            default: legal = 0;
        endcase
        if (ir[27:26] != 2'b00) legal = 0;
    endtask

    // ARM condition codes come in complementary pairs; the low bit inverts the predicate.
    function automatic bit cond_ok(input logic [3:0] cond, input logic [31:0] st);
        bit n, z, c, v, base;
        n = st[NZ+3]; z = st[NZ+2]; c = st[NZ+1]; v = st[NZ];
        if (cond == 4'hE) return 1;
        if (cond == 4'hF) return 0;
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = (n == v);
            default: base = ~z & (n == v);
        endcase
        return cond[0] ? !base : base;
    endfunction

    function automatic logic [127:0] exp_fields(input logic [31:0] ir);
        longint unsigned v8, r, rot;
        v8  = longint'(ir[7:0]);
        r   = 2 * longint'(ir[11:8]);
        rot = ((v8 >> r) | (v8 << (32 - r))) & 64'hFFFF_FFFF;
        return {44'b0, ir[15:12], ir[19:16], ir[3:0], ir[11:8], ir[6:5], ir[4], ir[25],
                32'(ir[11:7]), rot[31:0]};
    endfunction

    task automatic run(input logic [31:0] ir, input logic [31:0] st, input bit hold);
        bit legal, wr, mv, forced, go;
        logic [2:0] op;
        logic [127:0] ef;
        int n;
        decode(ir, legal, op, wr, mv, forced);
        go = legal && cond_ok(ir[31:28], st);
        ef = exp_fields(ir);
        n = 0;
        while (instr_ready !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        chk("ready_wait", 128'(instr_ready), 128'(1));
        instr = ir; instr_valid = 1'b1; status_in = st;
        @(negedge clk);
        instr_valid = hold; instr = $urandom;
        chk($sformatf("check_ctrl %h", ir), 128'(ctrl_obs), 128'(mk_ctrl(0,0,0,0,0,0,0,0,0)));
        chk($sformatf("check_fld %h", ir), fld_obs, ef);
        if (go) begin
            @(negedge clk);
            chk($sformatf("load_ctrl %h", ir), 128'(ctrl_obs), 128'(mk_ctrl(0,1,0,0,0,0,0,0,0)));
            @(negedge clk);
            chk($sformatf("exec_ctrl %h", ir), 128'(ctrl_obs),
                128'(mk_ctrl(0, 0, wr, ir[20] | forced, mv, op, 0, 0, 0)));
            chk($sformatf("exec_fld %h", ir), fld_obs, ef);
        end
        @(negedge clk);
        chk($sformatf("done_ctrl %h", ir), 128'(ctrl_obs),
            128'(mk_ctrl(0, 0, 0, 0, 0, 0, 1, legal && !go, !legal)));
        instr_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("idle_ctrl %h", ir), 128'(ctrl_obs), 128'(mk_ctrl(1,0,0,0,0,0,0,0,0)));
        chk($sformatf("idle_fld %h", ir), fld_obs, ef);
    endtask

    initial begin
        logic [3:0]  legal_ops [8] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd10, 4'd12, 4'd13};
        logic [31:0] r;
        bit          wen_seen;

        rst = 1'b1; instr_valid = 1'b0; instr = '0; status_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_ctrl", 128'(ctrl_obs), 128'(mk_ctrl(1,0,0,0,0,0,0,0,0)));
        chk("reset_fld", fld_obs, 128'(0));

        run(32'hE3A0102A, 32'h0, 0);
        chk("mov42_imm", 128'(imme_data), 128'(32'h2A));
        chk("mov42_rd", 128'(w_addr), 128'(1));
        run(32'hE3A014FF, 32'h0, 0);
        chk("imm_rot8", 128'(imme_data), 128'(32'hFF00_0000));
        run(32'hE0932184, 32'h0, 0);
        chk("adds_fields", 128'({A_addr, B_addr, shift_imme, w_addr}), 128'({4'd3, 4'd4, 32'd3, 4'd2}));
        run(32'h03A0102A, 32'h0000_0000, 0);
        run(32'h03A0102A, 32'h4000_0000, 0);
        run(32'hE1510002, 32'h0, 1);
        run(32'hE1A00231, 32'h0, 1);
        chk("lsr_reg_fields", 128'({shift_addr, sel_shift, shift_op, B_addr}), 128'({4'd2, 1'b1, 2'b01, 4'd1}));
        run(32'hE5912000, 32'h0, 1);

        // Reset while in LOAD must abort before any write-back.
        instr = 32'hE3A0102A; instr_valid = 1'b1; status_in = '0;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("abort_load", 128'(ctrl_obs), 128'(mk_ctrl(0,1,0,0,0,0,0,0,0)));
        rst = 1'b1;
        wen_seen = 0;
        @(negedge clk);
        wen_seen |= (w_en !== 1'b0);
        chk("abort_ctrl", 128'(ctrl_obs), 128'(mk_ctrl(1,0,0,0,0,0,0,0,0)));
        chk("abort_fld", fld_obs, 128'(0));
        rst = 1'b0;
        repeat (3) begin @(negedge clk); wen_seen |= (w_en !== 1'b0); end
        chk("abort_no_wen", 128'(wen_seen), 128'(0));
        chk("abort_idle", 128'(ctrl_obs), 128'(mk_ctrl(1,0,0,0,0,0,0,0,0)));

        for (int i = 0; i < 60; i++) begin
            r = $urandom;
            if ($urandom_range(0, 5) != 0) begin
                r[24:21] = legal_ops[$urandom_range(0, 7)];
                r[27:26] = 2'b00;
            end
            run(r, {$urandom_range(0, 15), 28'(r)}, bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule
